// File: rtl/rect_fill_engine.sv
// rect_fill_engine: rasterises clipped rectangle-fill commands into one framebuffer write per clock
// Ports: i_clk/i_reset_n clock and async active-low reset;
//   i_cmd_valid/o_cmd_ready command handshake, with fields i_cmd_x/y/w/h/color/flush;
//   o_wdata/o_waddr/o_we carry the pixel write port, o_flush is the buffer-swap pulse;
//   o_busy is high whenever the engine is not idle, o_done pulses when a command retires.
module rect_fill_engine #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 3
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [8:0]         i_cmd_x,
  input  logic [7:0]         i_cmd_y,
  input  logic [8:0]         i_cmd_w,
  input  logic [7:0]         i_cmd_h,
  input  logic [COLOR_W-1:0] i_cmd_color,
  input  logic               i_cmd_flush,
  output logic [COLOR_W-1:0] o_wdata,
  output logic [ADDR_W-1:0]  o_waddr,
  output logic               o_we,
  output logic               o_flush,
  output logic               o_busy,
  output logic               o_done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAW  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]        state, state_n;
  logic              rdy, fl, accept, empty, col_last, row_last;
  logic [8:0]        x0, col;
  logic [7:0]        row;
  logic [9:0]        cx1, cy1, ex, ey;
  logic [ADDR_W-1:0] row_base, base;
  assign accept      = i_cmd_valid & rdy;
  assign o_cmd_ready = rdy;
  assign o_we        = state == DRAW;
  assign o_flush     = state == FLUSH;
  assign o_done      = state == DONE;
  assign o_busy      = state != IDLE;
  // 10-bit sums cannot wrap: 511+511 and 255+255 both fit
  assign ex       = {1'b0, i_cmd_x} + {1'b0, i_cmd_w};
  assign ey       = {2'b0, i_cmd_y} + {2'b0, i_cmd_h};
  assign empty    = i_cmd_w == 9'd0 || i_cmd_h == 8'd0 ||
                    {1'b0, i_cmd_x} >= 10'(H_RES) || {2'b0, i_cmd_y} >= 10'(V_RES);
  // constant multiply only at acceptance; per-pixel stepping is add-only
  assign base     = ADDR_W'(i_cmd_y) * ADDR_W'(H_RES);
  assign col_last = {1'b0, col} + 10'd1 == cx1;
  assign row_last = {2'b0, row} + 10'd1 == cy1;
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = !accept ? IDLE : !empty ? DRAW : i_cmd_flush ? FLUSH : DONE;
    else if (state == DRAW)
      state_n = !(col_last && row_last) ? DRAW : fl ? FLUSH : DONE;
    else
      state_n = state == FLUSH ? DONE : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      rdy      <= 1'b0;
      fl       <= 1'b0;
      x0       <= '0;
      col      <= '0;
      row      <= '0;
      cx1      <= '0;
      cy1      <= '0;
      row_base <= '0;
      o_waddr  <= '0;
      o_wdata  <= '0;
    end else begin
      state <= state_n;
      rdy   <= state_n == IDLE;
      if (accept) begin
        x0       <= i_cmd_x;
        col      <= i_cmd_x;
        row      <= i_cmd_y;
        cx1      <= ex > 10'(H_RES) ? 10'(H_RES) : ex;
        cy1      <= ey > 10'(V_RES) ? 10'(V_RES) : ey;
        fl       <= i_cmd_flush;
        row_base <= base;
        // empty commands leave the write port untouched so it keeps its last value
        if (!empty) begin
          o_waddr <= base + ADDR_W'(i_cmd_x);
          o_wdata <= i_cmd_color;
        end
      end else if (state == DRAW && !col_last) begin
        col     <= col + 9'd1;
        o_waddr <= o_waddr + ADDR_W'(1);
      end else if (state == DRAW && !row_last) begin
        col      <= x0;
        row      <= row + 8'd1;
        row_base <= row_base + ADDR_W'(H_RES);
        o_waddr  <= row_base + ADDR_W'(H_RES) + ADDR_W'(x0);
      end
    end
  end
endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: directed self-checking bench for rect_fill_engine
module tb_rect_fill_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [8:0]  cx = '0;
  logic [7:0]  cy = '0;
  logic [8:0]  cw = '0;
  logic [7:0]  ch = '0;
  logic [2:0]  ccol = '0;
  logic        cfl = 1'b0;
  logic [2:0]  wdata;
  logic [16:0] waddr;
  logic        we, flush, busy, done;
  int          n_cmp = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  rect_fill_engine dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cmd_valid(valid), .o_cmd_ready(ready),
    .i_cmd_x(cx), .i_cmd_y(cy), .i_cmd_w(cw), .i_cmd_h(ch), .i_cmd_color(ccol),
    .i_cmd_flush(cfl), .o_wdata(wdata), .o_waddr(waddr), .o_we(we),
    .o_flush(flush), .o_busy(busy), .o_done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_cmd(input [8:0] x, input [7:0] y, input [8:0] w, input [7:0] h,
                         input [2:0] c, input f);
    cx = x; cy = y; cw = w; ch = h; ccol = c; cfl = f;
  endtask
  task automatic send(input [8:0] x, input [7:0] y, input [8:0] w, input [7:0] h,
                      input [2:0] c, input f);
    int t = 0;
    while (!ready && t < 200) begin cyc(); t++; end
    chk("send_ready", ready, 1);
    set_cmd(x, y, w, h, c, f);
    valid = 1'b1;
    cyc();
    valid = 1'b0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int bad;
    int ex_addr [6] = '{1610, 1611, 1612, 1930, 1931, 1932};
    int t6_addr [4] = '{5, 6, 325, 326};
    @(negedge clk); @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_flush", {done, flush}, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    rst_n = 1'b1;
    #1 chk("rel_ready_pre_clk", ready, 0);
    cyc();
    chk("rel_ready", ready, 1);
    // 3x2 fill at (10,5)
    send(10, 5, 3, 2, 3'b101, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t1_we", we, 1);
      chk("t1_addr", waddr, ex_addr[i]);
      chk("t1_data", wdata, 5);
      chk("t1_flush_done", {flush, done}, 0);
      chk("t1_ready", ready, 0);
      cyc();
    end
    chk("t1_end_we", we, 0);
    chk("t1_done", done, 1);
    chk("t1_flush", flush, 0);
    cyc();
    chk("t1_done_clear", done, 0);
    chk("t1_idle_ready", ready, 1);
    chk("t1_idle_busy", busy, 0);
    // clipped corner with flush
    send(318, 239, 10, 10, 3'b010, 1);
    chk("t2_we0", we, 1);
    chk("t2_addr0", waddr, 76798);
    chk("t2_data0", wdata, 2);
    cyc();
    chk("t2_we1", we, 1);
    chk("t2_addr1", waddr, 76799);
    cyc();
    chk("t2_flush_we", we, 0);
    chk("t2_flush", flush, 1);
    chk("t2_flush_nodone", done, 0);
    chk("t2_hold_addr", waddr, 76799);
    chk("t2_hold_data", wdata, 2);
    cyc();
    chk("t2_flush_clear", flush, 0);
    chk("t2_done", done, 1);
    cyc();
    chk("t2_ready", ready, 1);
    // empty commands
    send(0, 0, 0, 5, 3'b111, 1);
    chk("t3a_we", we, 0);
    chk("t3a_flush", flush, 1);
    chk("t3a_busy", busy, 1);
    cyc();
    chk("t3a_done", done, 1);
    chk("t3a_flush_clear", flush, 0);
    cyc();
    chk("t3a_ready_between", ready, 1);
    chk("t3a_hold_addr", waddr, 76799);
    send(400, 0, 5, 5, 3'b001, 0);
    chk("t3b_done", done, 1);
    chk("t3b_flush", flush, 0);
    chk("t3b_we", we, 0);
    cyc();
    chk("t3b_ready", ready, 1);
    chk("t3b_hold_data", wdata, 2);
    // full clear
    send(0, 0, 320, 240, 3'b000, 0);
    bad = 0;
    for (int i = 0; i < 76800; i++) begin
      if (!we || waddr != 17'(i) || ready || wdata != 3'd0) bad++;
      cyc();
    end
    chk("t4_bad_writes", bad, 0);
    chk("t4_end_we", we, 0);
    chk("t4_done", done, 1);
    cyc();
    // reset during the 4th write of a 3x3 fill at (2,3)
    send(2, 3, 3, 3, 3'b110, 0);
    cyc(); cyc(); cyc();
    chk("t5_4th_we", we, 1);
    chk("t5_4th_addr", waddr, 1282);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_we", we, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ready", ready, 0);
    @(posedge clk); @(negedge clk);
    chk("t5_in_rst_outs", {we, flush, done}, 0);
    rst_n = 1'b1;
    cyc();
    chk("t5_after_outs", {we, flush, done}, 0);
    chk("t5_after_ready", ready, 1);
    send(0, 1, 2, 1, 3'b100, 1);
    chk("t5_new_addr0", waddr, 320);
    chk("t5_new_data", wdata, 4);
    cyc();
    chk("t5_new_addr1", waddr, 321);
    cyc();
    chk("t5_new_flush", flush, 1);
    cyc();
    chk("t5_new_done", done, 1);
    cyc();
    // valid held with changing fields during DRAW
    set_cmd(5, 0, 2, 2, 3'b011, 0);
    valid = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("t6_we", we, 1);
      chk("t6_addr", waddr, t6_addr[i]);
      chk("t6_data", wdata, 3);
      chk("t6_ready", ready, 0);
      set_cmd(9'(50 + 17 * i), 8'(7 * i), 9'(i + 1), 8'(i + 1), 3'(i), 1);
      cyc();
    end
    set_cmd(100, 100, 1, 1, 3'b001, 0);
    chk("t6_done", done, 1);
    chk("t6_done_ready", ready, 0);
    cyc();
    chk("t6_idle_ready", ready, 1);
    chk("t6_idle_we", we, 0);
    cyc();
    valid = 1'b0;
    chk("t6_next_we", we, 1);
    chk("t6_next_addr", waddr, 32100);
    chk("t6_next_data", wdata, 1);
    cyc();
    chk("t6_next_done", done, 1);
    cyc();
    chk("t6_final_ready", ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Drawing engine directly upstream of the double-buffered video controller.
- Accepts rectangle-fill commands over a valid/ready handshake and rasterises each into one 3-bit write per clock into the 320x240 back buffer (linear address y*320+x).
- Optionally issues a one-cycle flush pulse after the last pixel so the controller swaps buffers.
- Provides the controller's i_wdata/i_waddr/i_we/i_flush inputs.

Parameters:
- H_RES, 320, framebuffer width in pixels.
- V_RES, 240, framebuffer height in pixels.
- ADDR_W, 17, write address width; must satisfy H_RES*V_RES <= 2^ADDR_W.
- COLOR_W, 3, pixel colour width (bit0 R, bit1 G, bit2 B).

Ports:
- i_clk  in  1  system clock, same domain as the video controller.
- i_reset_n  in  1  asynchronous active-low reset.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  engine can accept a command.
- i_cmd_x  in  9  left column of the rectangle.
- i_cmd_y  in  8  top row of the rectangle.
- i_cmd_w  in  9  width in pixels.
- i_cmd_h  in  8  height in pixels.
- i_cmd_color  in  COLOR_W  fill colour.
- i_cmd_flush  in  1  pulse o_flush after this rectangle completes.
- o_wdata  out  COLOR_W  pixel colour to the framebuffer.
- o_waddr  out  ADDR_W  pixel address to the framebuffer.
- o_we  out  1  write strobe.
- o_flush  out  1  buffer-swap request, one cycle wide.
- o_busy  out  1  engine not in IDLE.
- o_done  out  1  one-cycle pulse when a command fully retires.

Behaviour:
- Reset: asynchronous on i_reset_n low. State IDLE. o_we, o_flush, o_done, o_busy = 0. o_waddr, o_wdata = 0. o_cmd_ready = 0 while reset is asserted, then 1 from the first clock after deassertion.
- States: IDLE, DRAW, FLUSH, DONE.
- Handshake: a command is accepted on a rising edge where i_cmd_valid and o_cmd_ready are both 1. o_cmd_ready = 1 only in IDLE. Command fields are registered at acceptance; later changes on the inputs are ignored.
- Clipping, computed at acceptance:
  - cx1 = min(x+w, H_RES) and cy1 = min(y+h, V_RES), evaluated at 10 bits with no wrap.
  - The command is empty if w=0, h=0, x>=H_RES or y>=V_RES.
- Empty command: IDLE -> DONE (or -> FLUSH if the flush bit is set). No writes.
- Non-empty command: IDLE -> DRAW.
  - First write is presented on the cycle after acceptance (latency 1).
- DRAW:
  - Exactly one write per cycle, o_we=1, raster order: left to right, then top to bottom.
  - o_waddr = row_base + col, where row_base starts at y*H_RES.
  - Row base is updated incrementally (add H_RES on each row advance); no multiplier in the per-pixel path.
  - Column wraps from cx1-1 back to x; row increments on that wrap.
  - After the pixel (cx1-1, cy1-1): -> FLUSH if the flush bit is set, else -> DONE.
- FLUSH: o_flush=1 for exactly one cycle with o_we=0, then -> DONE.
- DONE: o_done=1 for one cycle, then -> IDLE. o_cmd_ready rises the following cycle.
- Minimum command period: pixels + 2 cycles without flush, pixels + 3 with flush.
- Between commands o_flush is always low for at least 2 cycles, so the controller's edge detector re-arms.
- o_we and o_flush are never high in the same cycle.
- o_waddr and o_wdata hold their last value when o_we=0.
- o_busy = (state != IDLE).
- Reset asserted mid-DRAW: writes stop immediately; the partial rectangle is abandoned; no flush and no done pulse.
- i_cmd_valid asserted while busy: no effect until IDLE; the command must be held by the source.

Test Plan:
- Reset, then cmd x=10 y=5 w=3 h=2 color=3'b101 flush=0 -> 6 writes on consecutive cycles starting 1 cycle after acceptance.
  - Addresses 1610, 1611, 1612, 1930, 1931, 1932, all with o_wdata=5.
  - o_done pulses 1 cycle after the last write; o_flush stays low.
- Cmd x=318 y=239 w=10 h=10 flush=1 -> clipped to 2 writes at addresses 76798 and 76799; o_flush high for 1 cycle the next cycle; o_done the cycle after.
- Cmd w=0 flush=1, then cmd x=400 flush=0 -> no o_we.
  - First command: o_flush pulses once.
  - Second command: only o_done pulses.
  - o_cmd_ready returns between the two commands.
- Full clear, x=0 y=0 w=320 h=240 color=0 -> exactly 76800 writes with addresses 0..76799 contiguous, and o_cmd_ready=0 throughout.
- Deassert i_reset_n on the 4th write of a 3x3 fill -> o_we=0 asynchronously with no further writes, and no o_done or o_flush; a new command after release executes normally.
- i_cmd_valid held high with changing fields during DRAW -> the current rectangle is unaffected; the next command is accepted only on the cycle o_cmd_ready=1.
